// File: rtl/mac_tx_framer.sv
// Egress MAC framer: wraps a streamed payload in preamble/SFD, zero-pads short
// frames, appends the CRC-32 FCS and enforces the inter-frame gap.
module mac_tx_framer #(
    parameter int MIN_LEN    = 60,
    parameter int IFG_CYCLES = 12,
    parameter int LEN_W      = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_er,
    output logic        tx_busy,
    output logic [31:0] stat_frames,
    output logic [15:0] stat_underruns
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_UNDR, S_DROP, S_IFG
    } state_t;

    localparam int               CNT_W   = $clog2(IFG_CYCLES + 8);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [LEN_W-1:0] len_reg;
    logic [31:0]      crc_reg;
    logic [31:0]      crc_calc;
    logic [31:0]      fcs_word;
    logic             last_seen_reg;
    logic             tx_en_reg, tx_er_reg;
    logic [7:0]       txd_reg;
    logic [31:0]      stat_frames_reg;
    logic [15:0]      stat_underruns_reg;

    logic             tx_en_next, tx_er_next;
    logic [7:0]       txd_next;
    logic             crc_upd;
    logic [7:0]       crc_byte;
    logic             accept;
    logic             pad_needed;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_calc   = crc32_byte(crc_reg, crc_byte);
    assign fcs_word   = ~crc_reg;
    assign accept     = in_valid && in_ready;
    // True while the byte being emitted this cycle still leaves the frame short.
    assign pad_needed = (32'(len_reg) + 32'd1) < 32'(MIN_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (in_valid) state_next = S_PRE;
            S_PRE:  if (cnt_reg == CNT_W'(6)) state_next = S_SFD;
            S_SFD:  state_next = S_DATA;
            S_DATA: begin
                if (!in_valid)    state_next = S_UNDR;
                else if (in_last) state_next = pad_needed ? S_PAD : S_FCS;
            end
            S_PAD:  if (!pad_needed) state_next = S_FCS;
            S_FCS:  if (cnt_reg == CNT_W'(3)) state_next = S_IFG;
            S_UNDR: state_next = last_seen_reg ? S_IFG : S_DROP;
            S_DROP: if (in_valid && in_last) state_next = S_IFG;
            S_IFG:  if (cnt_reg == CNT_W'(IFG_CYCLES - 1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        tx_en_next = 1'b0;
        tx_er_next = 1'b0;
        txd_next   = 8'h00;
        crc_upd    = 1'b0;
        crc_byte   = 8'h00;
        case (state_reg)
            S_PRE: begin
                tx_en_next = 1'b1;
                txd_next   = 8'h55;
            end
            S_SFD: begin
                tx_en_next = 1'b1;
                txd_next   = 8'hD5;
            end
            S_DATA: begin
                in_ready = 1'b1;
                // The stall cycle keeps tx_en up so the error cycle stays inside the frame.
                tx_en_next = 1'b1;
                if (in_valid) begin
                    txd_next = in_data;
                    crc_upd  = 1'b1;
                    crc_byte = in_data;
                end
            end
            S_PAD: begin
                tx_en_next = 1'b1;
                crc_upd    = 1'b1;
            end
            S_FCS: begin
                tx_en_next = 1'b1;
                txd_next   = fcs_word[{cnt_reg[1:0], 3'b000} +: 8];
            end
            S_UNDR: begin
                tx_en_next = 1'b1;
                tx_er_next = 1'b1;
            end
            S_DROP: in_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en_reg          <= 1'b0;
            tx_er_reg          <= 1'b0;
            txd_reg            <= 8'h00;
            crc_reg            <= 32'hFFFF_FFFF;
            len_reg            <= '0;
            last_seen_reg      <= 1'b0;
            stat_frames_reg    <= '0;
            stat_underruns_reg <= '0;
        end else begin
            tx_en_reg <= tx_en_next;
            tx_er_reg <= tx_er_next;
            txd_reg   <= txd_next;
            if (state_reg == S_SFD) begin
                crc_reg       <= 32'hFFFF_FFFF;
                len_reg       <= '0;
                last_seen_reg <= 1'b0;
            end else begin
                if (crc_upd) begin
                    crc_reg <= crc_calc;
                    if (len_reg != LEN_MAX) len_reg <= len_reg + LEN_W'(1);
                end
                if (state_reg == S_DATA && accept && in_last) last_seen_reg <= 1'b1;
            end
            if (state_reg == S_FCS && cnt_reg == CNT_W'(3))
                stat_frames_reg <= stat_frames_reg + 32'd1;
            if (state_reg == S_UNDR && stat_underruns_reg != 16'hFFFF)
                stat_underruns_reg <= stat_underruns_reg + 16'd1;
        end
    end

    assign gmii_tx_en     = tx_en_reg;
    assign gmii_tx_er     = tx_er_reg;
    assign gmii_txd       = txd_reg;
    assign tx_busy        = (state_reg != S_IDLE);
    assign stat_frames    = stat_frames_reg;
    assign stat_underruns = stat_underruns_reg;
endmodule
